// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder.
//   pptr_t       physical address (line address plus 4 offset bits)
//   cacheline_t  one cache line of data
//   state_t      responder service FSM states
//   line_addr()  strips the byte offset from a physical address
package mem_responder_pkg;

  localparam int PPTR_W           = 20;
  localparam int CLINE_W          = 128;
  localparam int LINE_OFFSET_BITS = 4;
  localparam int LAT_CNT_W        = 5;   // holds LATENCY-1 for LATENCY up to 31

  typedef logic [PPTR_W-1:0]                  pptr_t;
  typedef logic [CLINE_W-1:0]                 cacheline_t;
  typedef logic [PPTR_W-LINE_OFFSET_BITS-1:0] laddr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic laddr_t line_addr(input pptr_t addr);
    return addr[PPTR_W-1:LINE_OFFSET_BITS];
  endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Circular FIFO of pending read line addresses.
//   clk, rst     clock, asynchronous active-low reset
//   i_push       enqueue i_din (ignored when full)
//   i_pop        dequeue head (ignored when empty)
//   o_head       oldest entry
//   o_full/o_empty/o_count  occupancy
//   o_vld/o_addr per-entry valid bit and address, used for merge compares
module mem_req_fifo #(
  parameter int AW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic [AW-1:0]             i_din,
  output logic [AW-1:0]             o_head,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic [DEPTH-1:0]          o_vld,
  output logic [DEPTH-1:0][AW-1:0]  o_addr
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][AW-1:0] r_mem;
  logic [DEPTH-1:0]         r_vld;
  logic [PW-1:0]            r_wptr;
  logic [PW-1:0]            r_rptr;
  logic [PW:0]              r_count;
  logic                     w_do_push;
  logic                     w_do_pop;

  assign o_full    = (r_count == (PW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_vld   = r_vld;
  assign o_addr  = r_mem;

  // NOTE: the entry storage has no reset; r_vld qualifies every slot, so
  // stale contents are never observed and the array stays plain flops/RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_din;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      // Pop and push never target the same slot: pop needs count>0 and
      // push needs count<DEPTH, so the pointers differ when both fire.
      if (w_do_pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + 1'b1;
      end
      if (w_do_push) begin
        r_vld[r_wptr] <= 1'b1;
        r_wptr        <= r_wptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Line-granular main-memory model and synthesizable off-chip controller model.
//   clk, rst            clock, asynchronous active-low reset
//   mem_req_ren/raddr   read request (offset bits ignored)
//   mem_req_wen/waddr/wcacheline  line write, committed at the accepting edge
//   mem_rec_en          one-cycle response pulse
//   mem_rec_addr        line-aligned response address
//   mem_rec_cacheline   response data (with same-cycle write forwarding)
//   busy                a read is queued or in service
//   overflow            sticky: a read was dropped on a full queue
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int PADDR_W = PPTR_W,
  parameter int LINE_W  = CLINE_W,
  parameter int N_LINES = 1024,
  parameter int LATENCY = 5,
  parameter int QDEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_req_ren,
  input  logic [PADDR_W-1:0] mem_req_raddr,
  input  logic               mem_req_wen,
  input  logic [PADDR_W-1:0] mem_req_waddr,
  input  logic [LINE_W-1:0]  mem_req_wcacheline,
  output logic               mem_rec_en,
  output logic [PADDR_W-1:0] mem_rec_addr,
  output logic [LINE_W-1:0]  mem_rec_cacheline,
  output logic               busy,
  output logic               overflow
);

  localparam int LAW   = PADDR_W - LINE_OFFSET_BITS;
  localparam int IDX_W = $clog2(N_LINES);
  localparam int QCW   = $clog2(QDEPTH) + 1;

  logic [LINE_W-1:0] r_store [N_LINES];

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [LAT_CNT_W-1:0]     r_cnt;
  logic [LAT_CNT_W-1:0]     w_cnt_nxt;
  logic [LAW-1:0]           r_svc_laddr;
  logic [LAW-1:0]           w_load_addr;
  logic [LAW-1:0]           w_rd_laddr;
  logic [LAW-1:0]           w_wr_laddr;
  logic [IDX_W-1:0]         w_svc_idx;
  logic                     r_rec_en;
  logic [PADDR_W-1:0]       r_rec_addr;
  logic                     r_overflow;

  logic                     w_q_full;
  logic                     w_q_empty;
  logic [LAW-1:0]           w_q_head;
  logic [QCW-1:0]           w_q_count;
  logic [QDEPTH-1:0]        w_q_vld;
  logic [QDEPTH-1:0][LAW-1:0] w_q_addr;

  logic w_q_hit;
  logic w_svc_hit;
  logic w_new_rd;
  logic w_bypass;
  logic w_push;
  logic w_pop;
  logic w_load;
  logic w_fwd;
  logic w_unused;

  assign w_rd_laddr = mem_req_raddr[PADDR_W-1:LINE_OFFSET_BITS];
  assign w_wr_laddr = mem_req_waddr[PADDR_W-1:LINE_OFFSET_BITS];
  assign w_svc_idx  = r_svc_laddr[IDX_W-1:0];
  assign w_unused   = ^{mem_req_raddr[LINE_OFFSET_BITS-1:0],
                        mem_req_waddr[LINE_OFFSET_BITS-1:0]};

  // Backing store: written at the accepting edge, read combinationally in
  // the response cycle.
  always_ff @(posedge clk) begin
    if (mem_req_wen) r_store[w_wr_laddr[IDX_W-1:0]] <= mem_req_wcacheline;
  end

  // A stalled requester keeps ren high, so a read matching anything already
  // pending (queued or in service, including the RESP cycle) is absorbed.
  always_comb begin
    // NOTE: default first so no path through the loop leaves it unassigned,
    // which would otherwise infer a latch.
    w_q_hit = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (w_q_vld[i] && (w_q_addr[i] == w_rd_laddr)) w_q_hit = 1'b1;
    end
  end

  assign w_svc_hit = (r_state != ST_IDLE) && (r_svc_laddr == w_rd_laddr);
  assign w_new_rd  = mem_req_ren && !w_q_hit && !w_svc_hit;
  // An idle responder with nothing queued starts service directly.
  assign w_bypass  = w_new_rd && (r_state == ST_IDLE) && w_q_empty;
  assign w_push    = w_new_rd && !w_bypass;

  mem_req_fifo #(
    .AW    (LAW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_rd_laddr),
    .o_head  (w_q_head),
    .o_full  (w_q_full),
    .o_empty (w_q_empty),
    .o_count (w_q_count),
    .o_vld   (w_q_vld),
    .o_addr  (w_q_addr)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_load_addr = r_svc_laddr;
    case (r_state)
      ST_IDLE: begin
        if (!w_q_empty) begin
          w_pop       = 1'b1;
          w_load      = 1'b1;
          w_load_addr = w_q_head;
          w_state_nxt = ST_WAIT;
        end else if (w_bypass) begin
          w_load      = 1'b1;
          w_load_addr = w_rd_laddr;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) w_state_nxt = ST_RESP;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      ST_RESP: begin
        if (!w_q_empty) begin
          w_pop       = 1'b1;
          w_load      = 1'b1;
          w_load_addr = w_q_head;
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Service start at edge N plus LATENCY-1 WAIT decrements puts RESP in
    // cycle N+LATENCY.
    if (w_load) w_cnt_nxt = LAT_CNT_W'(LATENCY - 1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_svc_laddr <= '0;
      r_rec_en    <= 1'b0;
      r_rec_addr  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      if (w_load) r_svc_laddr <= w_load_addr;
      // RESP is only entered from WAIT, so r_svc_laddr is already current.
      r_rec_en   <= (w_state_nxt == ST_RESP);
      r_rec_addr <= (w_state_nxt == ST_RESP) ?
                    {r_svc_laddr, {LINE_OFFSET_BITS{1'b0}}} : '0;
      if (w_push && w_q_full) r_overflow <= 1'b1;
    end
  end

  // A write to the served line in the RESP cycle lands in the store only at
  // the closing edge, so forward it here.
  assign w_fwd = mem_req_wen && (w_wr_laddr == r_svc_laddr);

  assign mem_rec_en        = r_rec_en;
  assign mem_rec_addr      = r_rec_addr;
  assign mem_rec_cacheline = !r_rec_en ? '0 :
                             (w_fwd ? mem_req_wcacheline : r_store[w_svc_idx]);
  assign busy              = (w_q_count != '0) || (r_state != ST_IDLE);
  assign overflow          = r_overflow;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int LAT = 5;
  localparam int QD  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mem_req_ren = 1'b0;
  pptr_t      mem_req_raddr = '0;
  logic       mem_req_wen = 1'b0;
  pptr_t      mem_req_waddr = '0;
  cacheline_t mem_req_wcacheline = '0;
  logic       mem_rec_en;
  pptr_t      mem_rec_addr;
  cacheline_t mem_rec_cacheline;
  logic       busy;
  logic       overflow;

  mem_responder #(
    .LATENCY (LAT),
    .QDEPTH  (QD)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .mem_req_ren        (mem_req_ren),
    .mem_req_raddr      (mem_req_raddr),
    .mem_req_wen        (mem_req_wen),
    .mem_req_waddr      (mem_req_waddr),
    .mem_req_wcacheline (mem_req_wcacheline),
    .mem_rec_en         (mem_rec_en),
    .mem_rec_addr       (mem_rec_addr),
    .mem_rec_cacheline  (mem_rec_cacheline),
    .busy               (busy),
    .overflow           (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    pptr_t      addr;
    cacheline_t data;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t m_exp;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_resp   = 0;

  // Response monitor: every response must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && mem_rec_en) begin
      n_resp++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL resp_unexpected: got addr %h at cycle %0d, required no response",
                 mem_rec_addr, cyc);
      end else begin
        m_exp = sb.pop_front();
        n_checks++;
        if (mem_rec_addr !== m_exp.addr) begin
          n_fail++;
          $display("FAIL resp_addr: got %h, required %h", mem_rec_addr, m_exp.addr);
        end
        n_checks++;
        if (mem_rec_cacheline !== m_exp.data) begin
          n_fail++;
          $display("FAIL resp_data @%h: got %h, required %h",
                   m_exp.addr, mem_rec_cacheline, m_exp.data);
        end
        n_checks++;
        if (cyc !== m_exp.cyc) begin
          n_fail++;
          $display("FAIL resp_cycle @%h: got %0d, required %0d", m_exp.addr, cyc, m_exp.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic pptr_t aligned(input pptr_t a);
    return {line_addr(a), {LINE_OFFSET_BITS{1'b0}}};
  endfunction

  task automatic push_exp(input pptr_t a, input cacheline_t d, input int c);
    exp_t e;
    e.addr = aligned(a);
    e.data = d;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic do_write(input pptr_t a, input cacheline_t d);
    mem_req_wen        = 1'b1;
    mem_req_waddr      = a;
    mem_req_wcacheline = d;
    tick();
    mem_req_wen = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: %0d responses outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++;
    if (mem_rec_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b, required 0", mem_rec_en); end
    n_checks++;
    if (mem_rec_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h, required 0", mem_rec_addr); end
    n_checks++;
    if (mem_rec_cacheline !== '0) begin n_fail++; $display("FAIL reset_line: got %h, required 0", mem_rec_cacheline); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
    rst = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_latency();
    cacheline_t a5 = {16{8'hA5}};
    do_write(20'h00120, a5);
    tick();
    mem_req_ren   = 1'b1;
    mem_req_raddr = 20'h00120;
    push_exp(20'h00120, a5, cyc + 1 + LAT);
    tick();
    mem_req_ren = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL latency_busy: got %b, required 1", busy); end
    wait_drain(20, "latency");
    tick();
  endtask

  task automatic test_hold_read();
    int r0 = n_resp;
    mem_req_ren   = 1'b1;
    mem_req_raddr = 20'h00120;
    push_exp(20'h00120, {16{8'hA5}}, cyc + 1 + LAT);
    // Requester holds ren through the response cycle.
    repeat (LAT + 2) tick();
    mem_req_ren = 1'b0;
    wait_drain(20, "hold");
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_busy_fall: got %b, required 0", busy); end
    repeat (12) tick();
    n_checks++;
    if (n_resp - r0 !== 1) begin n_fail++; $display("FAIL hold_resp_count: got %0d, required 1", n_resp - r0); end
  endtask

  task automatic test_same_cycle_rw();
    cacheline_t db = {4{32'hDEADBEEF}};
    mem_req_wen        = 1'b1;
    mem_req_waddr      = 20'h00340;
    mem_req_wcacheline = db;
    mem_req_ren        = 1'b1;
    mem_req_raddr      = 20'h00347;
    push_exp(20'h00340, db, cyc + 1 + LAT);
    tick();
    mem_req_wen = 1'b0;
    mem_req_ren = 1'b0;
    wait_drain(20, "same_rw");
    tick();
  endtask

  task automatic test_overflow();
    int r0;
    int c0;
    for (int i = 0; i < 6; i++) do_write(pptr_t'(20'h00100 + 20'h10 * i), {4{32'h1000_0000 + i}});
    tick();
    r0 = n_resp;
    c0 = cyc;
    for (int i = 0; i < 6; i++) begin
      mem_req_ren   = 1'b1;
      mem_req_raddr = pptr_t'(20'h00100 + 20'h10 * i);
      if (i < 5) push_exp(mem_req_raddr, {4{32'h1000_0000 + i}}, c0 + 1 + LAT + i * (LAT + 1));
      tick();
    end
    mem_req_ren = 1'b0;
    wait_drain(60, "overflow");
    repeat (10) tick();
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: got %b, required 1", overflow); end
    n_checks++;
    if (n_resp - r0 !== 5) begin n_fail++; $display("FAIL overflow_resp_count: got %0d, required 5", n_resp - r0); end
  endtask

  task automatic test_resp_forward();
    cacheline_t old_d = {4{32'h0BAD_F00D}};
    cacheline_t new_d = {4{32'hC0FF_EE11}};
    do_write(20'h00200, old_d);
    tick();
    mem_req_ren   = 1'b1;
    mem_req_raddr = 20'h00200;
    push_exp(20'h00200, new_d, cyc + 1 + LAT);
    tick();
    mem_req_ren = 1'b0;
    repeat (LAT) tick();
    // Now inside the RESP cycle.
    do_write(20'h00200, new_d);
    wait_drain(10, "fwd");
    tick();
    mem_req_ren   = 1'b1;
    mem_req_raddr = 20'h00200;
    push_exp(20'h00200, new_d, cyc + 1 + LAT);
    tick();
    mem_req_ren = 1'b0;
    wait_drain(20, "fwd_reread");
    tick();
  endtask

  task automatic test_reset_mid();
    int r0 = n_resp;
    for (int i = 0; i < 4; i++) begin
      mem_req_ren   = 1'b1;
      mem_req_raddr = pptr_t'(20'h00400 + 20'h10 * i);
      tick();
    end
    mem_req_ren = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_overflow: got %b, required 0", overflow); end
    n_checks++;
    if (mem_rec_en !== 1'b0 || mem_rec_addr !== '0 || mem_rec_cacheline !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got en=%b addr=%h line=%h, required all 0",
               mem_rec_en, mem_rec_addr, mem_rec_cacheline);
    end
    repeat (2) tick();
    rst = 1'b1;
    repeat (40) tick();
    n_checks++;
    if (n_resp - r0 !== 0) begin n_fail++; $display("FAIL rstmid_resp_count: got %0d, required 0", n_resp - r0); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_after: got %b, required 0", busy); end
    mem_req_ren   = 1'b1;
    mem_req_raddr = 20'h00340;
    push_exp(20'h00340, {4{32'hDEADBEEF}}, cyc + 1 + LAT);
    tick();
    mem_req_ren = 1'b0;
    wait_drain(20, "rstmid_retain");
    tick();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_hold_read();
    test_same_cycle_rw();
    test_overflow();
    test_resp_forward();
    test_reset_mid();
    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
